// File: rtl/convolution_engine_if.sv
// ---------------------------------------------------------------------------
// convolution_engine_if
// Pixel-stream bundle between a raster source and the 3x3 filter core.
//   pixel_in        [7:0]  source -> core   input pixel, raster order
//   pixel_valid            source -> core   pixel_in qualifier
//   mode            [1:0]  source -> core   filter select travelling with pixel
//   pixel_out       [7:0]  core   -> sink   filtered pixel
//   pixel_out_valid        core   -> sink   single-cycle pixel_out qualifier
// master: pixel source / testbench side.  slave: filter core side.
// ---------------------------------------------------------------------------
interface convolution_engine_if;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic [1:0] mode;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;

  modport master (
    output pixel_in, pixel_valid, mode,
    input  pixel_out, pixel_out_valid
  );

  modport slave (
    input  pixel_in, pixel_valid, mode,
    output pixel_out, pixel_out_valid
  );
endinterface

// File: rtl/convolution_engine.sv
// ---------------------------------------------------------------------------
// convolution_engine
// Streaming 3x3 filter for 8-bit grayscale raster video, one pixel per clock.
// Two line buffers (one 16-bit wide RAM) feed a 3x3 window; mode selects
// passthrough (00), Sobel magnitude (01), Gaussian blur (10), sharpen (11).
// Every accepted pixel yields exactly one output LATENCY (=3) clocks later.
//
// Ports:
//   clk   rising-edge system clock
//   rst   asynchronous, active-high reset
//   bus   convolution_engine_if.slave (pixel_in, pixel_valid, mode,
//         pixel_out, pixel_out_valid)
//
// Build option: define CONV_EDGE_THRESHOLD_EN to binarize Sobel output
// against EDGE_THRESH (255 if magnitude >= EDGE_THRESH, else 0).
// ---------------------------------------------------------------------------
module convolution_engine #(
  parameter int IMG_WIDTH = 640,
  parameter int LATENCY   = 3
`ifdef CONV_EDGE_THRESHOLD_EN
  ,
  parameter int EDGE_THRESH = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  convolution_engine_if.slave  bus
);
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [CW-1:0]      col_reg;
  logic [1:0]         row_reg;
  // vld_reg[0]: stage 1 (RAM read done), [1]: window loaded, [2]: sums ready
  logic [LATENCY-1:0] vld_reg;

  logic [7:0]         s1_pix_reg;
  logic [CW-1:0]      s1_col_reg;
  logic [1:0]         s1_mode_reg, s2_mode_reg, s3_mode_reg;
  logic               s1_complete_reg, s2_complete_reg, s3_complete_reg;

  // Entry per column: [7:0] pixel one line earlier, [15:8] two lines earlier
  logic [15:0]        line_mem [IMG_WIDTH];
  logic [15:0]        line_rd_reg;

  // win_reg[row][col]: row 0 top, col 0 left; [2][2] is the newest pixel
  logic [7:0]         win_reg [3][3];
  logic [7:0]         right_col [3];

  logic [11:0]        mag_reg;
  logic [7:0]         gauss_reg;
  logic signed [11:0] ssum_reg;
  logic [7:0]         center_reg;

  logic [7:0]         pixel_out_reg;
  logic               pixel_out_valid_reg;

  logic               accept;
  assign accept = bus.pixel_valid;

  // Column/row position of the pixel being accepted this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_reg == CW'(IMG_WIDTH - 1)) begin
        col_reg <= '0;
        if (row_reg != 2'd2) row_reg <= row_reg + 2'd1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Valid pipeline: runs freely once a pixel is accepted, so bubbles never
  // stretch the latency of pixels already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_reg[0] <= 1'b0;
    else     vld_reg[0] <= accept;
  end

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_reg[gi] <= 1'b0;
        else     vld_reg[gi] <= vld_reg[gi-1];
      end
    end
  endgenerate

  // Stage 1: capture pixel and read the two older lines for this column
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pix_reg      <= bus.pixel_in;
      s1_mode_reg     <= bus.mode;
      s1_col_reg      <= col_reg;
      s1_complete_reg <= (row_reg == 2'd2) && (col_reg >= CW'(2));
      line_rd_reg     <= line_mem[col_reg];
    end
    // Write-back one cycle after the read; the same column is not touched
    // again for IMG_WIDTH (>=3) accepts, so read/write never collide.
    if (vld_reg[0]) begin
      line_mem[s1_col_reg] <= {line_rd_reg[7:0], s1_pix_reg};
    end
  end

  assign right_col[0] = line_rd_reg[15:8];
  assign right_col[1] = line_rd_reg[7:0];
  assign right_col[2] = s1_pix_reg;

  // Window shifts left only for accepted pixels
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win
      always_ff @(posedge clk) begin
        if (vld_reg[0]) begin
          win_reg[gi][0] <= win_reg[gi][1];
          win_reg[gi][1] <= win_reg[gi][2];
          win_reg[gi][2] <= right_col[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (vld_reg[0]) begin
      s2_mode_reg     <= s1_mode_reg;
      s2_complete_reg <= s1_complete_reg;
    end
  end

  // Stage 2: kernel sums from the window
  logic [9:0]         left_sum, right_sum, top_sum, bot_sum;
  logic signed [10:0] gx, gy;
  logic [10:0]        gx_u, gy_u, gx_abs, gy_abs;
  logic [11:0]        mag_c, gsum_c, five_c, neigh_c;
  logic signed [11:0] ssum_c;

  always_comb begin
    left_sum  = {2'b0, win_reg[0][0]} + {1'b0, win_reg[1][0], 1'b0} + {2'b0, win_reg[2][0]};
    right_sum = {2'b0, win_reg[0][2]} + {1'b0, win_reg[1][2], 1'b0} + {2'b0, win_reg[2][2]};
    top_sum   = {2'b0, win_reg[0][0]} + {1'b0, win_reg[0][1], 1'b0} + {2'b0, win_reg[0][2]};
    bot_sum   = {2'b0, win_reg[2][0]} + {1'b0, win_reg[2][1], 1'b0} + {2'b0, win_reg[2][2]};
    gx        = $signed({1'b0, right_sum}) - $signed({1'b0, left_sum});
    gy        = $signed({1'b0, bot_sum}) - $signed({1'b0, top_sum});
    gx_u      = gx;
    gy_u      = gy;
    gx_abs    = gx_u[10] ? (~gx_u + 11'd1) : gx_u;
    gy_abs    = gy_u[10] ? (~gy_u + 11'd1) : gy_u;
    mag_c     = {1'b0, gx_abs} + {1'b0, gy_abs};

    gsum_c    = {4'b0, win_reg[0][0]} + {3'b0, win_reg[0][1], 1'b0} + {4'b0, win_reg[0][2]}
              + {3'b0, win_reg[1][0], 1'b0} + {2'b0, win_reg[1][1], 2'b0} + {3'b0, win_reg[1][2], 1'b0}
              + {4'b0, win_reg[2][0]} + {3'b0, win_reg[2][1], 1'b0} + {4'b0, win_reg[2][2]};

    five_c    = {2'b0, win_reg[1][1], 2'b0} + {4'b0, win_reg[1][1]};
    neigh_c   = {4'b0, win_reg[0][1]} + {4'b0, win_reg[1][0]}
              + {4'b0, win_reg[1][2]} + {4'b0, win_reg[2][1]};
    ssum_c    = $signed(five_c) - $signed(neigh_c);
  end

  always_ff @(posedge clk) begin
    if (vld_reg[1]) begin
      mag_reg         <= mag_c;
      gauss_reg       <= 8'((gsum_c + 12'd8) >> 4);
      ssum_reg        <= ssum_c;
      center_reg      <= win_reg[2][2];
      s3_mode_reg     <= s2_mode_reg;
      s3_complete_reg <= s2_complete_reg;
    end
  end

  // Stage 3: per-mode saturation / selection
  logic [7:0] result_c;

  always_comb begin
    result_c = 8'd0;
    case (s3_mode_reg)
      2'b00: result_c = center_reg;
      2'b01: begin
        if (s3_complete_reg) begin
`ifdef CONV_EDGE_THRESHOLD_EN
          result_c = (mag_reg >= 12'(EDGE_THRESH)) ? 8'hFF : 8'h00;
`else
          result_c = (mag_reg > 12'd255) ? 8'hFF : mag_reg[7:0];
`endif
        end
      end
      2'b10: begin
        if (s3_complete_reg) result_c = gauss_reg;
      end
      default: begin
        if (s3_complete_reg) begin
          if (ssum_reg[11])             result_c = 8'h00;
          else if (|ssum_reg[10:8])     result_c = 8'hFF;
          else                          result_c = ssum_reg[7:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out_reg       <= 8'd0;
      pixel_out_valid_reg <= 1'b0;
    end else begin
      pixel_out_valid_reg <= vld_reg[LATENCY-1];
      if (vld_reg[LATENCY-1]) pixel_out_reg <= result_c;
    end
  end

  assign bus.pixel_out       = pixel_out_reg;
  assign bus.pixel_out_valid = pixel_out_valid_reg;
endmodule

// File: tb/tb_convolution_engine.sv
// ---------------------------------------------------------------------------
// tb_convolution_engine
// Scoreboard bench: the driver computes each expected output from a plain
// image-array reference model and queues it with its due cycle; a monitor
// compares on every pixel_out_valid.
// ---------------------------------------------------------------------------
module tb_convolution_engine;
  localparam int W      = 640;
  localparam int LAT    = 3;
  localparam int THRESH = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  convolution_engine_if bus();

  convolution_engine #(.IMG_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         due;
    int         idx;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   outputs_seen = 0;
  int   issued = 0;

  // Reference image: true line index modulo 8, full width
  int img [8][W];
  int m_line = 0;
  int m_col  = 0;

  function automatic logic [7:0] model(input int md);
    int w [3][3];
    int gx, gy, mag, s;
    if (md == 0) return 8'(img[m_line % 8][m_col]);
    if (m_line < 2 || m_col < 2) return 8'd0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[r][k] = img[(m_line - 2 + r) % 8][m_col - 2 + k];
    if (md == 1) begin
      gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
      gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
`ifdef CONV_EDGE_THRESHOLD_EN
      return (mag >= THRESH) ? 8'd255 : 8'd0;
`else
      return 8'(mag);
`endif
    end
    if (md == 2) begin
      s = w[0][0] + 2*w[0][1] + w[0][2] + 2*w[1][0] + 4*w[1][1] + 2*w[1][2]
        + w[2][0] + 2*w[2][1] + w[2][2];
      return 8'((s + 8) / 16);
    end
    s = 5*w[1][1] - w[0][1] - w[1][0] - w[1][2] - w[2][1];
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  task automatic send(input int pix, input int md);
    exp_t e;
    @(negedge clk);
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'(pix);
    bus.mode        = 2'(md);
    img[m_line % 8][m_col] = pix & 255;
    e.val = model(md);
    e.due = cyc + 1 + LAT;
    e.idx = issued;
    issued++;
    sb_q.push_back(e);
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_line++;
    end
  endtask

  task automatic bubble();
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = 8'($urandom_range(0, 255));
    bus.mode        = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n;
    n = 0;
    bubble();
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.pixel_valid = 1'b0;
    #1;
    vectors++;
    if (bus.pixel_out !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_pixel_out got=%0d required=0", bus.pixel_out);
    end
    vectors++;
    if (bus.pixel_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got=%0b required=0", bus.pixel_out_valid);
    end
    sb_q.delete();
    m_line = 0;
    m_col  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT presents an output
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.pixel_out_valid === 1'b1) begin
      outputs_seen++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got=%0d required=none", bus.pixel_out);
      end else begin
        e = sb_q.pop_front();
        if (bus.pixel_out !== e.val || cyc != e.due) begin
          miscompares++;
          $display("FAIL pixel idx=%0d got=%0d@%0d required=%0d@%0d",
                   e.idx, bus.pixel_out, cyc, e.val, e.due);
        end else begin
          $display("out idx=%0d val=%0d cyc=%0d ok", e.idx, bus.pixel_out, cyc);
        end
      end
    end
  end

  initial begin
    int base;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = 8'd0;
    bus.mode        = 2'd0;

    do_reset();

    // Passthrough
    base = outputs_seen;
    for (int i = 0; i < 3*W; i++) send(i % 256, 0);
    drain();
    vectors++;
    if (outputs_seen - base != 3*W) begin
      miscompares++;
      $display("FAIL passthrough_count got=%0d required=%0d", outputs_seen - base, 3*W);
    end

    // Sobel ramp
    do_reset();
    for (int i = 0; i < 3*W; i++) send((i % W) % 256, 1);
    drain();

    // Gaussian flat
    do_reset();
    for (int i = 0; i < 3*W; i++) send(128, 2);
    drain();

    // Sharpen flat, then an isolated 255 among zeros
    do_reset();
    for (int i = 0; i < 3*W; i++) send(200, 3);
    for (int i = 0; i < 3*W; i++) send((i / W == 1 && i % W == 10) ? 255 : 0, 3);
    drain();

    // Bubbles every other cycle with a mid-line 00 -> 10 switch
    do_reset();
    for (int i = 0; i < 3*W; i++) begin
      send($urandom_range(0, 255), (i < W + W/2) ? 0 : 2);
      bubble();
    end
    drain();

    // Random pixels, modes and bubbles
    do_reset();
    for (int i = 0; i < 4*W; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bubble();
    end
    drain();

    // Reset mid-line at row 1, col 300, then restart the ramp
    do_reset();
    for (int i = 0; i < W + 300; i++) send((i % W) % 256, 1);
    do_reset();
    for (int i = 0; i < 3*W; i++) send((i % W) % 256, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
